mac_seq: RTL and testbench
==========================

MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter: DEPTH, 4, operand FIFO depth in pairs (power of two, >=2).
REQ-002 Parameter: WDOG, 16, cycles allowed in WAIT before the watchdog fires.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand pair offered.
REQ-006 in_ready  out  1  FIFO can accept a pair (= not full).
REQ-007 in_mplier  in  4  multiplier operand.
REQ-008 in_mcand  in  4  multiplicand operand.
REQ-009 in_last  in  1  pair closes the current accumulation group.
REQ-010 mult_st  out  1  start pulse to the shift-add multiplier.
REQ-011 mult_mplier  out  4  operand to multiplier, held stable from START until WAIT exits.
REQ-012 mult_mcand  out  4  operand to multiplier, held stable as above.
REQ-013 mult_done  in  1  multiplier completion strobe.
REQ-014 mult_result  in  8  product, valid only while mult_done=1.
REQ-015 out_valid  out  1  group sum available.
REQ-016 out_ready  in  1  consumer accepts sum.
REQ-017 out_sum  out  12  accumulated group sum.
REQ-018 out_ovf  out  1  group sum wrapped past 4095.
REQ-019 err  out  1  sticky watchdog error.

Function
REQ-020 FIFO stores {mplier, mcand, last}; push on in_valid&&in_ready; in_ready=0 when count==DEPTH; no push when full.
REQ-021 Push and pop in the same cycle leave the count unchanged; pointers wrap modulo DEPTH.
REQ-022 FSM states: IDLE, START, WAIT, OUT.
REQ-023 IDLE: if FIFO non-empty, pop head into mult_mplier/mult_mcand and a last_q register, go START; else stay.
REQ-024 START: mult_st=1 for exactly this one cycle; go WAIT. mult_st SHALL be 0 in every other state.
REQ-025 WAIT: on mult_done=1, sum <= sum + {4'b0, mult_result} (12-bit modulo); out_ovf set if carry out of bit 11; then go OUT if last_q else IDLE.
REQ-026 WAIT: a watchdog counter starts at 0 on entry; if mult_done stays 0 for WDOG cycles, set err=1, discard the item (sum unchanged), go IDLE.
REQ-027 mult_done outside WAIT SHALL be ignored.
REQ-028 OUT: out_valid=1, out_sum/out_ovf stable; on out_ready=1 clear sum and out_ovf, go IDLE; hold indefinitely while out_ready=0.
REQ-029 FIFO accepts pushes in every state, including OUT and WAIT.
REQ-030 Latency, empty FIFO in IDLE: pair pushed at edge E0, popped at E1, mult_st high during cycle E1-E2, WAIT entered at E2; out_valid rises on the edge after mult_done is sampled for a last pair.
REQ-031 Zero product (either operand 0) is accumulated like any other result.
REQ-032 err clears only on rst; err does not block further operation.

Reset
REQ-033 rst=1 at any edge: FSM->IDLE, FIFO empty, sum=0, out_ovf=0, err=0, out_valid=0, mult_st=0, mult_mplier=0, mult_mcand=0, watchdog=0; in_ready=1 from the following cycle.
REQ-034 Reset mid-group discards the partial sum and queued pairs; a stale mult_done after reset is ignored per REQ-027.

Verification
REQ-035 Push (3,5,last=1), multiplier model 9-cycle latency -> mult_st single pulse with mult_mplier=3/mult_mcand=5; out_sum=15, out_ovf=0.
REQ-036 Push (15,15,0),(15,15,0),(2,3,1) -> exactly three mult_st pulses; out_sum=456.
REQ-037 Hold multiplier busy, push 5 pairs back-to-back -> in_ready falls after the 4th accepted push; the 5th is accepted only after the next pop.
REQ-038 Push 19 x (15,15), the last with in_last=1 -> out_sum=179 (4275 mod 4096), out_ovf=1; next group starts from sum=0, ovf=0.
REQ-039 out_ready=0 for 10 cycles in OUT -> out_valid and out_sum held; queued pairs not issued until handshake.
REQ-040 mult_done tied 0 after START -> err=1 exactly WDOG cycles after WAIT entry, FSM returns to IDLE; rst mid-WAIT clears err and the FIFO.

Source files
------------

// File: rtl/mac_seq.sv
// Sequential multiply-accumulate front end: queues operand pairs and issues them one at a time
// to an external shift-add multiplier. It sums the products per group and guards each wait with a watchdog.
module mac_seq #(
  parameter int DEPTH = 4,
  parameter int WDOG  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_mplier,
  input  logic [3:0]  in_mcand,
  input  logic        in_last,
  output logic        mult_st,
  output logic [3:0]  mult_mplier,
  output logic [3:0]  mult_mcand,
  input  logic        mult_done,
  input  logic [7:0]  mult_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_sum,
  output logic        out_ovf,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(WDOG + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t          state_reg, state_next;
  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            push, pop;
  logic [3:0]      mplier_reg, mcand_reg;
  logic            last_reg;
  logic [11:0]     sum_reg, sum_next;
  logic            ovf_reg, ovf_next;
  logic            err_reg, err_next;
  logic [WW-1:0]   wdog_reg, wdog_next;
  logic [12:0]     acc;

  assign in_ready    = (count_reg != CW'(DEPTH));
  assign push        = in_valid && in_ready;
  assign mult_st     = (state_reg == START);
  assign out_valid   = (state_reg == OUT);
  assign mult_mplier = mplier_reg;
  assign mult_mcand  = mcand_reg;
  assign out_sum     = sum_reg;
  assign out_ovf     = ovf_reg;
  assign err         = err_reg;

  // Storage array has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {in_mplier, in_mcand, in_last};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Registered read of the FIFO head doubles as the operand hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mplier_reg <= '0;
      mcand_reg  <= '0;
      last_reg   <= 1'b0;
    end else if (pop) begin
      {mplier_reg, mcand_reg, last_reg} <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sum_reg   <= '0;
      ovf_reg   <= 1'b0;
      err_reg   <= 1'b0;
      wdog_reg  <= '0;
    end else begin
      state_reg <= state_next;
      sum_reg   <= sum_next;
      ovf_reg   <= ovf_next;
      err_reg   <= err_next;
      wdog_reg  <= wdog_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    sum_next   = sum_reg;
    ovf_next   = ovf_reg;
    err_next   = err_reg;
    wdog_next  = wdog_reg;
    acc        = {1'b0, sum_reg} + {5'b0, mult_result};
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        wdog_next  = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // A completion on the final watchdog cycle still counts.
        if (mult_done) begin
          sum_next   = acc[11:0];
          ovf_next   = ovf_reg | acc[12];
          state_next = last_reg ? OUT : IDLE;
        end else if (wdog_reg == WW'(WDOG - 1)) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          wdog_next = wdog_reg + WW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          sum_next   = '0;
          ovf_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: table-driven groups, a behavioural multiplier model,
// and a scoreboard of expected group sums checked on each output handshake.
module tb_mac_seq;

  localparam int DEPTH = 4;
  localparam int WDOG  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_mplier;
  logic [3:0]  in_mcand;
  logic        in_last;
  logic        mult_st;
  logic [3:0]  mult_mplier;
  logic [3:0]  mult_mcand;
  logic        mult_done;
  logic [7:0]  mult_result;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic        out_ovf;
  logic        err;

  mac_seq #(.DEPTH(DEPTH), .WDOG(WDOG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mplier(in_mplier), .in_mcand(in_mcand), .in_last(in_last),
    .mult_st(mult_st), .mult_mplier(mult_mplier), .mult_mcand(mult_mcand),
    .mult_done(mult_done), .mult_result(mult_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] sum;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [3:0]  mp;
    logic [3:0]  mc;
    logic        last;
    logic [11:0] esum;
    logic        eovf;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // multiplier model controls
  int   lat        = 9;
  bit   done_en    = 1'b1;
  bit   stale_req  = 1'b0;
  int   st_count   = 0;
  int   done_count = 0;
  bit   busy       = 1'b0;
  int   cnt        = 0;
  logic [7:0] prod = '0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Multiplier model: all activity on the falling edge, away from the DUT's sampling edge.
  initial begin
    mult_done   = 1'b0;
    mult_result = '0;
    forever begin
      @(negedge clk);
      mult_done = 1'b0;
      if (stale_req) begin
        mult_done   = 1'b1;
        mult_result = 8'd99;
        stale_req   = 1'b0;
      end else if (busy) begin
        if (cnt <= 1) begin
          busy = 1'b0;
          if (done_en) begin
            mult_done   = 1'b1;
            mult_result = prod;
            done_count++;
          end
        end else begin
          cnt--;
        end
      end
      if (mult_st) begin
        st_count++;
        busy = 1'b1;
        cnt  = lat;
        prod = 8'(mult_mplier * mult_mcand);
      end
    end
  end

  // Scoreboard consumer: one line per completed group.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          $display("group: sum=%0d ovf=%0d (want sum=%0d ovf=%0d)", out_sum, out_ovf, e.sum, e.ovf);
          chk("group_sum", int'(out_sum), int'(e.sum));
          chk("group_ovf", int'(out_ovf), int'(e.ovf));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [3:0] mp, input logic [3:0] mc, input logic last, output int waits);
    in_mplier = mp;
    in_mcand  = mc;
    in_last   = last;
    in_valid  = 1'b1;
    waits     = 0;
    while (!in_ready && waits < 300) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready)
      chk("push_timeout", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (sb.size() > 0 && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    cyc(2);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    vec_t tbl[7];
    int   w;
    int   st_base;
    int   done_base;
    int   n;
    exp_t e;

    tbl[0] = '{4'd15, 4'd15, 1'b0, 12'd0,   1'b0};
    tbl[1] = '{4'd15, 4'd15, 1'b0, 12'd0,   1'b0};
    tbl[2] = '{4'd2,  4'd3,  1'b1, 12'd456, 1'b0};
    tbl[3] = '{4'd0,  4'd7,  1'b1, 12'd0,   1'b0};
    tbl[4] = '{4'd4,  4'd4,  1'b0, 12'd0,   1'b0};
    tbl[5] = '{4'd9,  4'd0,  1'b1, 12'd16,  1'b0};
    tbl[6] = '{4'd13, 4'd11, 1'b1, 12'd143, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_mplier = '0; in_mcand = '0; in_last = 1'b0; out_ready = 1'b1;
    cyc(3);
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_mult_st", int'(mult_st), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_ovf", int'(out_ovf), 0);
    chk("rst_mplier", int'(mult_mplier), 0);
    chk("rst_mcand", int'(mult_mcand), 0);

    // Single pair, 9-cycle multiplier: latency and single start pulse.
    lat = 9;
    st_base = st_count;
    e = '{12'd15, 1'b0}; sb.push_back(e);
    push(4'd3, 4'd5, 1'b1, w);
    chk("lat_st_e0", int'(mult_st), 0);
    cyc(1);
    chk("lat_st_e1", int'(mult_st), 1);
    chk("lat_mplier", int'(mult_mplier), 3);
    chk("lat_mcand", int'(mult_mcand), 5);
    cyc(1);
    chk("lat_st_e2", int'(mult_st), 0);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!mult_done && n < 40);
    chk("done_seen", int'(mult_done), 1);
    chk("ov_before", int'(out_valid), 0);
    @(negedge clk); #1;
    chk("ov_after", int'(out_valid), 1);
    cyc(1);
    drain(50);
    chk("single_st_pulses", st_count - st_base, 1);

    // Table-driven groups.
    lat = 3;
    st_base = st_count;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].last) begin
        e = '{tbl[i].esum, tbl[i].eovf};
        sb.push_back(e);
      end
      push(tbl[i].mp, tbl[i].mc, tbl[i].last, w);
      $display("push: mplier=%0d mcand=%0d last=%0d waits=%0d", tbl[i].mp, tbl[i].mc, tbl[i].last, w);
    end
    drain(400);
    chk("table_st_pulses", st_count - st_base, 7);

    // 19 x 225 wraps past 4095; the following group must start clean.
    lat = 1;
    e = '{12'd179, 1'b1}; sb.push_back(e);
    for (int i = 0; i < 19; i++)
      push(4'd15, 4'd15, (i == 18), w);
    e = '{12'd4, 1'b0}; sb.push_back(e);
    push(4'd2, 4'd2, 1'b1, w);
    drain(400);

    // Consumer stall in OUT: output held, queued pair not issued.
    lat = 2;
    out_ready = 1'b0;
    e = '{12'd2, 1'b0}; sb.push_back(e);
    push(4'd1, 4'd2, 1'b1, w);
    e = '{12'd9, 1'b0}; sb.push_back(e);
    push(4'd3, 4'd3, 1'b1, w);
    n = 0;
    while (!out_valid && n < 100) begin
      cyc(1);
      n++;
    end
    chk("stall_reach_out", int'(out_valid), 1);
    st_base = st_count;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_sum", int'(out_sum), 2);
    end
    chk("hold_no_issue", st_count - st_base, 0);
    out_ready = 1'b1;
    drain(100);

    // FIFO full while multiplier busy.
    lat = 12;
    e = '{12'd6, 1'b0}; sb.push_back(e);
    push(4'd1, 4'd1, 1'b0, w);
    cyc(3);
    done_base = done_count;
    for (int i = 0; i < 4; i++)
      push(4'd1, 4'd1, 1'b0, w);
    chk("full_in_ready", int'(in_ready), 0);
    push(4'd1, 4'd1, 1'b1, w);
    chk("fifth_stalled", int'(w > 0), 1);
    chk("fifth_after_pop", int'(done_count - done_base >= 1), 1);
    drain(400);

    // Watchdog: no completion after start.
    lat = 2;
    done_en = 1'b0;
    push(4'd2, 4'd2, 1'b1, w);
    cyc(1);
    chk("wd_st", int'(mult_st), 1);
    cyc(1);
    cyc(WDOG - 1);
    chk("wd_err_early", int'(err), 0);
    cyc(1);
    chk("wd_err_fire", int'(err), 1);
    chk("wd_no_out", int'(out_valid), 0);
    done_en = 1'b1;
    e = '{12'd3, 1'b0}; sb.push_back(e);
    push(4'd3, 4'd1, 1'b1, w);
    drain(100);
    chk("err_sticky", int'(err), 1);

    // Reset mid-WAIT clears err and queued pairs; a stale completion is ignored.
    done_en = 1'b0;
    push(4'd5, 4'd5, 1'b1, w);
    push(4'd1, 4'd1, 1'b1, w);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    sb.delete();
    chk("rst2_err", int'(err), 0);
    chk("rst2_out_valid", int'(out_valid), 0);
    chk("rst2_sum", int'(out_sum), 0);
    chk("rst2_in_ready", int'(in_ready), 1);
    st_base = st_count;
    done_en = 1'b1;
    stale_req = 1'b1;
    cyc(20);
    chk("rst2_fifo_empty", st_count - st_base, 0);
    chk("rst2_stale_sum", int'(out_sum), 0);
    e = '{12'd3, 1'b0}; sb.push_back(e);
    push(4'd1, 4'd3, 1'b1, w);
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
